// File: rtl/reg_cmd_master_pkg.sv
// Shared widths, payload structs and FSM state type for the register command master.
package reg_cmd_master_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_cmd_t;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/reg_cmd_master_if.sv
// Command stream, response stream and reg_ctrl bus of the register command master.
interface reg_cmd_master_if;
  import reg_cmd_master_pkg::*;

  // valid/ready: a transfer happens on a posedge where both are high; the valid
  // side keeps its payload stable until that edge. The reg_ctrl bus works the same
  // way with sel as valid and ready as ready.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              sel;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
    output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, sel, wr, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, ready,
    input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, sel, wr, addr, wdata
  );
endinterface

// File: rtl/reg_cmd_master_fifo.sv
// Two-entry command buffer; read side sees a new entry one cycle after it is written.
module reg_cmd_master_fifo
  import reg_cmd_master_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  reg_cmd_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output reg_cmd_t out_data
);
  reg_cmd_t   mem [2];
  logic       wp;
  logic       rp;
  logic       vis_q;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = vis_q;
  assign out_data  = mem[rp];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
      vis_q <= 1'b0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
      // Popping the last entry hides the head at once; anything else lags count by one edge.
      vis_q <= (count != 2'd0) && !(pop && count == 2'd1);
    end
  end
endmodule

// File: rtl/reg_cmd_master.sv
// Drives reg_ctrl from a buffered command stream, one transaction at a time, with a
// ready watchdog and one in-order response per command.
module reg_cmd_master
  import reg_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  reg_cmd_master_if.master bus,
  output state_e           dbg_state
);
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  reg_cmd_t          in_cmd;
  reg_cmd_t          head;
  logic              head_valid;
  logic              head_pop;
  state_e            state;
  logic [CNT_W-1:0]  wd_cnt;
  logic              sel_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  reg_rsp_t          rsp_q;
  logic              rsp_valid_q;

  assign in_cmd   = '{wr: bus.cmd_wr, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign head_pop = (state == IDLE);

  reg_cmd_master_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.cmd_valid),
    .in_ready  (bus.cmd_ready),
    .in_data   (in_cmd),
    .out_valid (head_valid),
    .out_ready (head_pop),
    .out_data  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (head_valid) begin
            sel_q   <= 1'b1;
            wr_q    <= head.wr;
            addr_q  <= head.addr;
            wdata_q <= head.wdata;
            wd_cnt  <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (sel_q && bus.ready) begin
            sel_q  <= 1'b0;
            wr_q   <= 1'b0;
            wd_cnt <= '0;
            if (wr_q) begin
              rsp_q       <= '{wr: 1'b1, rdata: '0, err: 1'b0};
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              state <= RDWAIT;
            end
          end else if (wd_cnt == CNT_LAST) begin
            // Abandon the request: reg_ctrl never sees an accept edge for it.
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            wd_cnt      <= CNT_SAT;
            rsp_q       <= '{wr: wr_q, rdata: '0, err: 1'b1};
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        RDWAIT: begin
          if (bus.ready) begin
            rsp_q       <= '{wr: 1'b0, rdata: bus.rdata, err: 1'b0};
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (wd_cnt == CNT_LAST) begin
            wd_cnt      <= CNT_SAT;
            rsp_q       <= '{wr: 1'b0, rdata: '0, err: 1'b1};
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_q.wr;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign dbg_state     = state;
endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: reg_ctrl responder, response scoreboard against a
// memory-level reference model, directed vector table, corner sequences, random traffic.
module tb_reg_cmd_master;
  import reg_cmd_master_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  reg_cmd_master_if bus ();

  reg_cmd_master #(.TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- shared state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] exp_q[$];
  logic [15:0] model_mem [256];
  logic [15:0] slave_mem [256];
  bit          force_low, rand_stall, rand_lat, done;
  int          rd_lat, rd_left, wr_accepts, rsp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: commands complete in order, so a read returns the memory image left by
  // every earlier accepted write; a timed-out command leaves memory untouched.
  function automatic logic [17:0] model_rsp(input logic w, input logic [7:0] a,
                                            input logic [15:0] d, input bit err);
    if (err) return {w, 16'h0, 1'b1};
    if (w) begin
      model_mem[a] = d;
      return {1'b1, 16'h0, 1'b0};
    end
    return {1'b0, model_mem[a], 1'b0};
  endfunction

  // ---------------- reg_ctrl responder ----------------
  logic        s_acc, s_wr, s_rst, s_stall;
  logic [7:0]  s_addr;
  logic [15:0] s_wdata;
  initial begin
    bus.ready = 1'b1;
    bus.rdata = 16'h0;
    rd_left   = 0;
    forever begin
      @(negedge clk);
      s_acc = bus.sel && bus.ready && !rst;
      s_wr = bus.wr; s_addr = bus.addr; s_wdata = bus.wdata; s_rst = rst;
      @(posedge clk); #2;
      if (s_rst) rd_left = 0;
      else if (s_acc) begin
        if (s_wr) begin
          slave_mem[s_addr] = s_wdata;
          wr_accepts++;
        end else begin
          bus.rdata = slave_mem[s_addr];
          rd_left = (rand_lat ? int'($urandom_range(1, 4)) : rd_lat) - 1;
        end
      end else if (rd_left > 0) rd_left--;
      s_stall   = rand_stall ? ($urandom_range(0, 3) == 0) : force_low;
      bus.ready = (rd_left == 0) && !s_stall;
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [17:0] got;
  initial forever begin
    @(negedge clk);
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      got = {bus.rsp_wr, bus.rsp_rdata, bus.rsp_err};
      if (exp_q.size() == 0) check("rsp_unexpected", 32'(exp_q.size()), 1);
      else check("rsp_scoreboard", 32'(got), 32'(exp_q.pop_front()));
      rsp_count++;
    end
  end

  logic        hold_pend = 1'b0;
  logic [25:0] hold_bus;
  initial forever begin
    @(negedge clk);
    if (hold_pend && !rst && dbg_state == REQ)
      check("bus_hold", 32'({bus.sel, bus.wr, bus.addr, bus.wdata}), 32'(hold_bus));
    hold_pend = bus.sel && !bus.ready && !rst;
    hold_bus  = {bus.sel, bus.wr, bus.addr, bus.wdata};
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [15:0] d, input bit err);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_wr = w; bus.cmd_addr = a; bus.cmd_wdata = d;
    @(negedge clk);
    while (!bus.cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (bus.cmd_ready) exp_q.push_back(model_rsp(w, a, d, err));
    else check("cmd_accept_timeout", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                        output int lat, output int sel_cyc, output logic [17:0] rsp);
    send_cmd(w, a, d, 1'b0);
    lat = 0; sel_cyc = 0;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.sel) sel_cyc++;
    end
    rsp = {bus.rsp_wr, bus.rsp_rdata, bus.rsp_err};
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < budget) begin @(posedge clk); #1; n++; end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_sel(input string name);
    int n = 0;
    while (!bus.sel && n < 20) begin @(posedge clk); #1; n++; end
    check(name, 32'(bus.sel), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_rdata;
    int          exp_cyc;
  } vec_t;
  vec_t vecs [7];

  int          lat, sel_cyc, k, w0, c0;
  logic [17:0] rsp;
  logic        seen, r_wr;
  logic [7:0]  r_addr;
  logic [15:0] r_data;

  initial begin
    vecs[0] = '{1'b1, 8'haa, 16'he513, 1, 16'h0000, 3};
    vecs[1] = '{1'b0, 8'haa, 16'h0000, 2, 16'he513, 5};
    vecs[2] = '{1'b1, 8'h55, 16'h1234, 1, 16'h0000, 3};
    vecs[3] = '{1'b0, 8'h55, 16'h0000, 1, 16'h1234, 4};
    vecs[4] = '{1'b0, 8'h00, 16'h0000, 3, 16'h0000, 6};
    vecs[5] = '{1'b1, 8'hff, 16'hffff, 1, 16'h0000, 3};
    vecs[6] = '{1'b0, 8'hff, 16'h0000, 4, 16'hffff, 7};
    foreach (model_mem[i]) begin model_mem[i] = 16'h0; slave_mem[i] = 16'h0; end
    force_low = 0; rand_stall = 0; rand_lat = 0; done = 0; rd_lat = 1;
    wr_accepts = 0; rsp_count = 0;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 8'h0; bus.cmd_wdata = 16'h0;
    bus.rsp_ready = 1'b1;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_bus", 32'({bus.wr, bus.addr, bus.wdata}), 0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_wr, bus.rsp_rdata, bus.rsp_err}), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: latency from command accept to rsp_valid, one-cycle bus strobe
    for (int i = 0; i < 7; i++) begin
      rd_lat = vecs[i].lat;
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, sel_cyc, rsp);
      check("vec_latency", 32'(lat), 32'(vecs[i].exp_cyc));
      check("vec_sel_cycles", 32'(sel_cyc), 1);
      check("vec_rsp", 32'(rsp), 32'({vecs[i].wr, vecs[i].exp_rdata, 1'b0}));
    end
    rd_lat = 1;

    // ready low for 10 cycles at REQ: bus held, single write lands
    w0 = wr_accepts;
    force_low = 1;
    send_cmd(1'b1, 8'h33, 16'hbeef, 1'b0);
    wait_sel("stall_sel_seen");
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", 32'({bus.sel, bus.wr, bus.addr, bus.wdata}), 32'({2'b11, 8'h33, 16'hbeef}));
      @(posedge clk); #1;
    end
    force_low = 0;
    drain(100);
    check("stall_single_write", 32'(wr_accepts - w0), 1);
    check("stall_mem", 32'(slave_mem[8'h33]), 32'h0000beef);

    // ready stuck low: watchdog error after 64 cycles, then normal read
    w0 = wr_accepts;
    force_low = 1;
    send_cmd(1'b1, 8'haa, 16'h0bad, 1'b1);
    wait_sel("wd_sel_seen");
    k = 0;
    while (!bus.rsp_valid && k < 200) begin @(posedge clk); #1; k++; end
    check("wd_cycles", 32'(k), 64);
    check("wd_rsp", 32'({bus.rsp_wr, bus.rsp_rdata, bus.rsp_err}), 32'({1'b1, 16'h0, 1'b1}));
    check("wd_sel_drop", 32'(bus.sel), 0);
    force_low = 0;
    drain(100);
    check("wd_no_write", 32'(wr_accepts - w0), 0);
    rd_lat = 2;
    do_txn(1'b0, 8'haa, 16'h0, lat, sel_cyc, rsp);
    check("wd_next_read", 32'(rsp), 32'({1'b0, 16'he513, 1'b0}));
    rd_lat = 1;

    // Response back-pressure: buffer fills, then three in-order responses
    c0 = rsp_count;
    bus.rsp_ready = 1'b0;
    send_cmd(1'b1, 8'h10, 16'h0001, 1'b0);
    send_cmd(1'b0, 8'h10, 16'h0000, 1'b0);
    send_cmd(1'b1, 8'h10, 16'h0002, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
    check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    check("bp_rsp_held", 32'(rsp_count - c0), 0);
    bus.rsp_ready = 1'b1;
    drain(100);
    check("bp_rsp_count", 32'(rsp_count - c0), 3);

    // Reset during RDWAIT: everything back to reset values, no response
    rd_lat = 8;
    send_cmd(1'b0, 8'h55, 16'h0, 1'b0);
    k = 0;
    while (dbg_state != RDWAIT && k < 20) begin @(posedge clk); #1; k++; end
    check("rst_mid_reached", 32'(dbg_state), 32'(RDWAIT));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rst_mid_bus", 32'({bus.sel, bus.wr, bus.addr, bus.wdata}), 0);
    check("rst_mid_rsp", 32'({bus.rsp_valid, bus.rsp_wr, bus.rsp_rdata, bus.rsp_err}), 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", 32'(seen), 0);
    rd_lat = 1;
    do_txn(1'b0, 8'h55, 16'h0, lat, sel_cyc, rsp);
    check("rst_recover_read", 32'(rsp), 32'({1'b0, 16'h1234, 1'b0}));

    // Random traffic against the reference model
    rand_stall = 1; rand_lat = 1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          r_wr   = 1'($urandom_range(0, 1));
          r_addr = 8'h40 + 8'($urandom_range(0, 7));
          r_data = 16'($urandom);
          send_cmd(r_wr, r_addr, r_data, 1'b0);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1;
      end
      begin
        while (!done) begin
          bus.rsp_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
      end
    join
    drain(2000);
    rand_stall = 0; rand_lat = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
